// File: rtl/vx_victim_sel_if.sv
// Request/response bundle between the miss path, the victim selector and the fill logic.
interface vx_victim_sel_if #(
    parameter int unsigned NUM_WAYS = 4
) ();
    localparam int unsigned WAY_BITS = $clog2(NUM_WAYS);

    logic                req_valid;
    logic                req_ready;
    logic [NUM_WAYS-1:0] req_valid_mask;
    logic [NUM_WAYS-1:0] req_lock_mask;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WAY_BITS-1:0] rsp_way;
    logic                rsp_evict;
    logic                rsp_none;

    modport master (
        output req_valid, req_valid_mask, req_lock_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_way, rsp_evict, rsp_none
    );

    modport slave (
        input  req_valid, req_valid_mask, req_lock_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_way, rsp_evict, rsp_none
    );
endinterface

// File: rtl/vx_victim_sel.sv
// Random-replacement victim selector: prefers invalid ways, never picks locked ways,
// resamples the PRNG a bounded number of times before a wrap-around scan.
module vx_victim_sel #(
    parameter int unsigned NUM_WAYS  = 4,
    parameter int unsigned RND_BITS  = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RND_BITS-1:0] rnd,
    vx_victim_sel_if.slave      bus
);
    localparam int unsigned WAY_BITS = $clog2(NUM_WAYS);
    localparam int unsigned CNT_BITS = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PICK = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [NUM_WAYS-1:0] valid_q, valid_n;
    logic [NUM_WAYS-1:0] lock_q, lock_n;
    logic [CNT_BITS-1:0] retry_q, retry_n;
    logic                ready_q, ready_n;
    logic                rsp_valid_q, rsp_valid_n;
    logic [WAY_BITS-1:0] way_q, way_n;
    logic                evict_q, evict_n;
    logic                none_q, none_n;

    logic [NUM_WAYS-1:0] eligible;
    logic [NUM_WAYS-1:0] free;
    logic [WAY_BITS-1:0] cand;
    logic [WAY_BITS-1:0] free_idx;
    logic [WAY_BITS-1:0] fb_idx;
    logic [WAY_BITS-1:0] scan_idx;

    assign eligible = ~lock_q;
    assign free     = eligible & ~valid_q;
    assign cand     = rnd[WAY_BITS-1:0];

    if (RND_BITS > WAY_BITS) begin : g_rnd_high
        logic unused_rnd_high;
        assign unused_rnd_high = ^rnd[RND_BITS-1:WAY_BITS];
    end

    // Lowest free way, and first eligible way after cand in wrap-around order.
    always_comb begin
        free_idx = '0;
        fb_idx   = '0;
        scan_idx = '0;
        for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
            if (free[i]) free_idx = WAY_BITS'(i);
        end
        for (int k = int'(NUM_WAYS) - 1; k >= 1; k--) begin
            scan_idx = cand + WAY_BITS'(k);
            if (eligible[scan_idx]) fb_idx = scan_idx;
        end
    end

    always_comb begin
        state_n = state;
        valid_n = valid_q;
        lock_n  = lock_q;
        retry_n = retry_q;
        way_n   = way_q;
        evict_n = evict_q;
        none_n  = none_q;
        unique case (state)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    valid_n = bus.req_valid_mask;
                    lock_n  = bus.req_lock_mask;
                    retry_n = '0;
                    state_n = S_PICK;
                end
            end
            S_PICK: begin
                if (eligible == '0) begin
                    way_n   = '0;
                    evict_n = 1'b0;
                    none_n  = 1'b1;
                    state_n = S_RSP;
                end else if (free != '0) begin
                    way_n   = free_idx;
                    evict_n = 1'b0;
                    none_n  = 1'b0;
                    state_n = S_RSP;
                end else if (eligible[cand]) begin
                    way_n   = cand;
                    evict_n = 1'b1;
                    none_n  = 1'b0;
                    state_n = S_RSP;
                end else if (32'(retry_q) < MAX_RETRY) begin
                    retry_n = retry_q + CNT_BITS'(1);
                end else begin
                    way_n   = fb_idx;
                    evict_n = 1'b1;
                    none_n  = 1'b0;
                    state_n = S_RSP;
                end
            end
            S_RSP: begin
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        ready_n     = (state_n == S_IDLE);
        rsp_valid_n = (state_n == S_RSP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            valid_q     <= '0;
            lock_q      <= '0;
            retry_q     <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            way_q       <= '0;
            evict_q     <= 1'b0;
            none_q      <= 1'b0;
        end else begin
            state       <= state_n;
            valid_q     <= valid_n;
            lock_q      <= lock_n;
            retry_q     <= retry_n;
            ready_q     <= ready_n;
            rsp_valid_q <= rsp_valid_n;
            way_q       <= way_n;
            evict_q     <= evict_n;
            none_q      <= none_n;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_way   = way_q;
    assign bus.rsp_evict = evict_q;
    assign bus.rsp_none  = none_q;
endmodule

// File: tb/tb_vx_victim_sel.sv
// Bench for vx_victim_sel: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vx_victim_sel;
    localparam int unsigned NUM_WAYS  = 4;
    localparam int unsigned RND_BITS  = 16;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned WAY_BITS  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [RND_BITS-1:0] rnd;

    vx_victim_sel_if #(.NUM_WAYS(NUM_WAYS)) bus ();

    vx_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .RND_BITS (RND_BITS),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rnd  (rnd),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: outcome of one request given the masks and the rnd seen in each PICK cycle.
    function automatic void ref_pick(input logic [3:0] v, input logic [3:0] l,
                                     input logic [WAY_BITS-1:0] c[$],
                                     output int way, output int ev, output int none,
                                     output int picks);
        logic [3:0] elig;
        logic [3:0] fr;
        elig  = ~l;
        fr    = elig & ~v;
        way   = 0;
        ev    = 0;
        none  = 0;
        picks = 1;
        if (elig == 4'b0000) begin
            none = 1;
            return;
        end
        if (fr != 4'b0000) begin
            for (int i = 3; i >= 0; i--) if (fr[i]) way = i;
            return;
        end
        for (int i = 0; i <= int'(MAX_RETRY); i++) begin
            picks = i + 1;
            if (i >= c.size()) return;
            if (elig[c[i]]) begin
                way = int'(c[i]);
                ev  = 1;
                return;
            end
        end
        for (int k = 1; k < int'(NUM_WAYS); k++) begin
            int w;
            w = (int'(c[MAX_RETRY]) + k) % int'(NUM_WAYS);
            if (elig[w]) begin
                way = w;
                ev  = 1;
                return;
            end
        end
    endfunction

    // rnd driver: free-running random unless a forced value is requested
    bit                  force_rnd = 1'b0;
    logic [RND_BITS-1:0] rnd_force = '0;
    initial rnd = '0;
    always @(posedge clk) begin
        #1 rnd = force_rnd ? rnd_force : RND_BITS'($urandom);
    end

    // Cycle monitor driven by the transaction model
    bit                  started = 1'b0;
    bit                  rst_prev = 1'b0;
    bit                  busy = 1'b0;
    bit                  have_rsp = 1'b0;
    logic [3:0]          m_valid, m_lock;
    logic [WAY_BITS-1:0] rq[$];
    int                  e_way, e_ev, e_none, e_picks;

    initial begin
        @(posedge clk);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            if (!rst_prev) begin
                check("rst_req_ready", 32'(bus.req_ready), 0);
                check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
                check("rst_rsp_way", 32'(bus.rsp_way), 0);
                check("rst_rsp_evict", 32'(bus.rsp_evict), 0);
                check("rst_rsp_none", 32'(bus.rsp_none), 0);
                busy     = 1'b0;
                have_rsp = 1'b0;
                rq.delete();
            end else if (!busy) begin
                check("idle_req_ready", 32'(bus.req_ready), 1);
                check("idle_rsp_valid", 32'(bus.rsp_valid), 0);
                if (bus.req_valid) begin
                    busy    = 1'b1;
                    m_valid = bus.req_valid_mask;
                    m_lock  = bus.req_lock_mask;
                    rq.delete();
                end
            end else if (!have_rsp) begin
                check("busy_req_ready", 32'(bus.req_ready), 0);
                if (!bus.rsp_valid) begin
                    rq.push_back(rnd[WAY_BITS-1:0]);
                    if (rq.size() > MAX_RETRY + 1) begin
                        check("rsp_timeout", 32'(rq.size()), 32'(MAX_RETRY + 1));
                        busy = 1'b0;
                    end
                end else begin
                    ref_pick(m_valid, m_lock, rq, e_way, e_ev, e_none, e_picks);
                    check("pick_cycles", 32'(rq.size()), 32'(e_picks));
                    check("rsp_way", 32'(bus.rsp_way), 32'(e_way));
                    check("rsp_evict", 32'(bus.rsp_evict), 32'(e_ev));
                    check("rsp_none", 32'(bus.rsp_none), 32'(e_none));
                    have_rsp = 1'b1;
                    if (bus.rsp_ready) begin
                        busy     = 1'b0;
                        have_rsp = 1'b0;
                    end
                end
            end else begin
                check("hold_req_ready", 32'(bus.req_ready), 0);
                check("hold_rsp_valid", 32'(bus.rsp_valid), 1);
                check("hold_rsp_way", 32'(bus.rsp_way), 32'(e_way));
                check("hold_rsp_evict", 32'(bus.rsp_evict), 32'(e_ev));
                check("hold_rsp_none", 32'(bus.rsp_none), 32'(e_none));
                if (bus.rsp_ready) begin
                    busy     = 1'b0;
                    have_rsp = 1'b0;
                end
            end
            rst_prev = reset;
        end
    end

    // Drive a request and return just after the accepting edge.
    task automatic start_req(input logic [3:0] v, input logic [3:0] l);
        int cnt;
        @(posedge clk);
        #1;
        bus.req_valid      = 1'b1;
        bus.req_valid_mask = v;
        bus.req_lock_mask  = l;
        cnt = 0;
        @(negedge clk);
        while (!bus.req_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus.req_ready) check("accept_timeout", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Count cycles after the accepting edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat, input int sw_cycle, input logic [RND_BITS-1:0] sw_rnd);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == sw_cycle) rnd_force = sw_rnd;
        end while (!bus.rsp_valid && lat < 20);
    endtask

    task automatic do_req(input string tag, input logic [3:0] v, input logic [3:0] l,
                          input int hold, input int x_way, input int x_ev, input int x_none,
                          input int x_lat, input int sw_cycle, input logic [RND_BITS-1:0] sw_rnd);
        int lat;
        bus.rsp_ready = (hold == 0);
        start_req(v, l);
        wait_rsp(lat, sw_cycle, sw_rnd);
        check({tag, "_lat"}, 32'(lat), 32'(x_lat));
        check({tag, "_way"}, 32'(bus.rsp_way), 32'(x_way));
        check({tag, "_evict"}, 32'(bus.rsp_evict), 32'(x_ev));
        check({tag, "_none"}, 32'(bus.rsp_none), 32'(x_none));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_bp_valid"}, 32'(bus.rsp_valid), 1);
            check({tag, "_bp_way"}, 32'(bus.rsp_way), 32'(x_way));
            check({tag, "_bp_none"}, 32'(bus.rsp_none), 32'(x_none));
            check({tag, "_bp_ready"}, 32'(bus.req_ready), 0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(bus.req_ready), 1);
        check({tag, "_valid_after"}, 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [WAY_BITS-1:0] pq[$];
        int pw, pe, pn, pp;
        int lat;

        // Pin the reference model against hand-computed cases
        pq = '{2'd0, 2'd0, 2'd0, 2'd0};
        ref_pick(4'b1111, 4'b1101, pq, pw, pe, pn, pp);
        check("model_fallback_way", 32'(pw), 1);
        check("model_fallback_picks", 32'(pp), 4);
        pq = '{2'd0, 2'd3};
        ref_pick(4'b1111, 4'b0101, pq, pw, pe, pn, pp);
        check("model_retry_way", 32'(pw), 3);
        check("model_retry_picks", 32'(pp), 2);

        reset              = 1'b0;
        bus.req_valid      = 1'b1;
        bus.req_valid_mask = 4'b1011;
        bus.req_lock_mask  = 4'b0000;
        bus.rsp_ready      = 1'b1;

        // Reset held 3 cycles with a request pending
        repeat (3) begin
            @(negedge clk);
            check("por_req_ready", 32'(bus.req_ready), 0);
            check("por_rsp_valid", 32'(bus.rsp_valid), 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);

        do_req("invalid_pref", 4'b1011, 4'b0000, 0, 2, 0, 0, 2, 0, '0);
        do_req("all_invalid", 4'b0000, 4'b0000, 0, 0, 0, 0, 2, 0, '0);

        @(negedge clk);
        force_rnd = 1'b1;
        rnd_force = 16'd3;
        do_req("rand_evict", 4'b1111, 4'b0000, 0, 3, 1, 0, 2, 0, '0);

        @(negedge clk);
        rnd_force = 16'd0;
        do_req("fallback", 4'b1111, 4'b1101, 0, 1, 1, 0, 5, 0, '0);

        @(negedge clk);
        rnd_force = 16'd0;
        do_req("retry_hit", 4'b1111, 4'b1101, 0, 1, 1, 0, 3, 1, 16'd1);

        @(negedge clk);
        force_rnd = 1'b0;
        do_req("all_locked", 4'b1010, 4'b1111, 5, 0, 0, 1, 2, 0, '0);

        // Reset while retries are pending
        @(negedge clk);
        force_rnd = 1'b1;
        rnd_force = 16'd0;
        bus.rsp_ready = 1'b1;
        start_req(4'b1111, 4'b1101);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_pick_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_pick_req_ready", 32'(bus.req_ready), 0);
        do_req("after_rst_pick", 4'b0000, 4'b0000, 0, 0, 0, 0, 2, 0, '0);

        // Reset while a response is held
        @(negedge clk);
        rnd_force = 16'd2;
        bus.rsp_ready = 1'b0;
        start_req(4'b1111, 4'b0000);
        wait_rsp(lat, 0, '0);
        check("rsp_before_rst_way", 32'(bus.rsp_way), 2);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_rsp_rsp_valid", 32'(bus.rsp_valid), 0);
        do_req("after_rst_rsp", 4'b0111, 4'b0001, 0, 3, 0, 0, 2, 0, '0);

        // Randomized traffic, checked by the monitor
        @(negedge clk);
        force_rnd = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            bus.req_valid      = ($urandom_range(0, 1) == 1);
            bus.req_valid_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            bus.req_lock_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom & $urandom);
            bus.rsp_ready      = ($urandom_range(0, 3) != 0);
            reset              = ($urandom_range(0, 99) != 0);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        reset         = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
